// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle LEGv8 sequencing FSM with ready handshakes and sticky wait-timeout fault
module multicycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [10:0] Opcode,
  input  logic        Zero,
  input  logic        IMemReady,
  input  logic        DMemReady,
  output logic        IMemReq,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        Reg2Loc,
  output logic        ALUSrc,
  output logic [1:0]  ALUOp,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        Fault,
  output logic [2:0]  State
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CL_NOP   = 3'd0,
    CL_LDUR  = 3'd1,
    CL_STUR  = 3'd2,
    CL_CBZ   = 3'd3,
    CL_B     = 3'd4,
    CL_SHIFT = 3'd5,
    CL_IMM   = 3'd6,
    CL_RTYPE = 3'd7
  } class_e;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  class_e           class_q, class_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  class_e           dec_class;

  logic       imem_req, ir_write, pc_write, pc_src, reg2loc, alu_src;
  logic [1:0] alu_op;
  logic       mem_read, mem_write, mem_to_reg, reg_write, fault;

  // Priority decode: first matching pattern wins, so order matters.
  always_comb begin
    dec_class = CL_NOP;
    casez (Opcode)
      11'b11111000010: dec_class = CL_LDUR;
      11'b11111000000: dec_class = CL_STUR;
      11'b10110100???: dec_class = CL_CBZ;
      11'b000101?????: dec_class = CL_B;
      11'b1101001101?: dec_class = CL_SHIFT;
      11'b1??100??00?: dec_class = CL_IMM;
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: dec_class = CL_RTYPE;
      default:         dec_class = CL_NOP;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_FETCH;
      class_q <= CL_NOP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    cnt_d      = '0;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg2loc    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    fault      = 1'b0;

    // ALU steering is held through MEM so the address stays stable during the wait.
    if (state_q == ST_EXEC || state_q == ST_MEM) begin
      alu_src = (class_q == CL_LDUR) || (class_q == CL_STUR) ||
                (class_q == CL_SHIFT) || (class_q == CL_IMM);
      reg2loc = (class_q == CL_STUR) || (class_q == CL_CBZ);
      if (class_q == CL_LDUR || class_q == CL_STUR) begin
        alu_op = 2'b00;
      end else if (class_q == CL_CBZ) begin
        alu_op = 2'b01;
      end else begin
        alu_op = 2'b10;
      end
    end

    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (IMemReady) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DECODE: begin
        class_d = dec_class;
        if (dec_class == CL_NOP) begin
          pc_write = 1'b1;
          state_d  = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (class_q)
          CL_CBZ: begin
            pc_write = 1'b1;
            pc_src   = Zero;
            state_d  = ST_FETCH;
          end
          CL_B: begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
            state_d  = ST_FETCH;
          end
          CL_LDUR, CL_STUR: state_d = ST_MEM;
          default:          state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_read  = (class_q == CL_LDUR);
        mem_write = (class_q == CL_STUR);
        if (DMemReady) begin
          if (class_q == CL_LDUR) begin
            state_d = ST_WB;
          end else begin
            pc_write = 1'b1;
            state_d  = ST_FETCH;
          end
        end else if (cnt_q == TIMEOUT_C) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (class_q == CL_LDUR);
        pc_write   = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_FAULT: begin
        fault   = 1'b1;
        alu_src = 1'b0;
        reg2loc = 1'b0;
        alu_op  = 2'b00;
        state_d = ST_FAULT;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Reset masks every strobe in the cycle it is asserted, whatever the state.
  always_comb begin
    IMemReq  = imem_req   & ~Reset;
    IRWrite  = ir_write   & ~Reset;
    PCWrite  = pc_write   & ~Reset;
    PCSrc    = pc_src     & ~Reset;
    Reg2Loc  = reg2loc    & ~Reset;
    ALUSrc   = alu_src    & ~Reset;
    ALUOp    = alu_op     & {2{~Reset}};
    MemRead  = mem_read   & ~Reset;
    MemWrite = mem_write  & ~Reset;
    MemToReg = mem_to_reg & ~Reset;
    RegWrite = reg_write  & ~Reset;
    Fault    = fault      & ~Reset;
    State    = state_q;
  end

endmodule
